prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 125 ++++++++++++
 tb/tb_prog_loader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses HEADER/LEN/DATA/CSUM frames into a 256x8
// program memory and holds the core while a frame is in flight.
module prog_loader #(
    parameter logic [7:0] HEADER  = 8'hA5,
    parameter int         TIMEOUT = 1000
) (
    input  logic       Clock,
    input  logic       nReset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       hold,
    output logic       done,
    output logic       error
);

    localparam int IW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LEN  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_CSUM = 2'd3;

    logic [1:0]    r_state;
    logic          r_ready;
    logic          r_we;
    logic [7:0]    r_memAddr;
    logic [7:0]    r_memWdata;
    logic          r_hold;
    logic          r_done;
    logic          r_error;
    logic [7:0]    r_wrAddr;
    logic [8:0]    r_remaining;
    logic [7:0]    r_csum;
    logic [IW-1:0] r_idle;

    logic w_xfer;
    logic w_timeout;

    assign w_xfer    = rx_valid && r_ready;
    assign w_timeout = (r_state != S_IDLE) && !w_xfer && (r_idle == IW'(TIMEOUT - 1));

    // Remaining count is 9 bits so that a length byte of 0 can stand for 256.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b0;
            r_we        <= 1'b0;
            r_memAddr   <= 8'd0;
            r_memWdata  <= 8'd0;
            r_hold      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_wrAddr    <= 8'd0;
            r_remaining <= 9'd0;
            r_csum      <= 8'd0;
            r_idle      <= '0;
        end else begin
            r_ready <= 1'b1;
            r_we    <= 1'b0;

            if (r_state == S_IDLE || w_xfer) begin
                r_idle <= '0;
            end else begin
                r_idle <= r_idle + IW'(1);
            end

            if (w_timeout) begin
                r_error <= 1'b1;
                r_hold  <= 1'b0;
                r_state <= S_IDLE;
            end else if (w_xfer) begin
                case (r_state)
                    S_IDLE: begin
                        if (rx_data == HEADER) begin
                            r_state  <= S_LEN;
                            r_hold   <= 1'b1;
                            r_done   <= 1'b0;
                            r_error  <= 1'b0;
                            r_csum   <= 8'd0;
                            r_wrAddr <= 8'd0;
                        end
                    end
                    S_LEN: begin
                        r_remaining <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                        r_state     <= S_DATA;
                    end
                    S_DATA: begin
                        r_we        <= 1'b1;
                        r_memAddr   <= r_wrAddr;
                        r_memWdata  <= rx_data;
                        r_wrAddr    <= r_wrAddr + 8'd1;
                        r_csum      <= r_csum + rx_data;
                        r_remaining <= r_remaining - 9'd1;
                        if (r_remaining == 9'd1) begin
                            r_state <= S_CSUM;
                        end
                    end
                    S_CSUM: begin
                        if (rx_data == r_csum) begin
                            r_done <= 1'b1;
                        end else begin
                            r_error <= 1'b1;
                        end
                        r_hold  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign rx_ready  = r_ready;
    assign mem_we    = r_we;
    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;
    assign hold      = r_hold;
    assign done      = r_done;
    assign error     = r_error;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader: frame parsing, checksum,
// timeout abort, reset abort and 256-byte wrap.
module tb_prog_loader;

    localparam int TB_TIMEOUT = 20;

    logic       Clock;
    logic       nReset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       hold;
    logic       done;
    logic       error;

    int assertCount = 0;
    int failCount   = 0;
    int cycleCount  = 0;
    int writeCount  = 0;
    int writeCycleLog [1024];
    int addrLog       [1024];
    int dataLog       [1024];
    logic [7:0] shadowMem [256];
    int startW;
    int badCount;

    prog_loader #(
        .HEADER (8'hA5),
        .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .Clock    (Clock),
        .nReset   (nReset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .hold     (hold),
        .done     (done),
        .error    (error)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) cycleCount++;

    // Write monitor samples mid-cycle so every strobe is seen exactly once.
    always @(negedge Clock) begin
        if (mem_we === 1'b1) begin
            shadowMem[mem_addr]         = mem_wdata;
            writeCycleLog[writeCount % 1024] = cycleCount;
            addrLog[writeCount % 1024]  = int'(mem_addr);
            dataLog[writeCount % 1024]  = int'(mem_wdata);
            writeCount++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge Clock);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    initial begin
        nReset   = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #2 nReset = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        checkOutput("rstReady", rx_ready, 0);
        checkOutput("rstWe",    mem_we, 0);
        checkOutput("rstAddr",  mem_addr, 0);
        checkOutput("rstWdata", mem_wdata, 0);
        checkOutput("rstFlags", {hold, done, error}, 0);
        #2 nReset = 1'b1;
        #1 checkOutput("readyLowBeforeEdge", rx_ready, 0);
        @(posedge Clock);
        #1 checkOutput("readyAfterEdge", rx_ready, 1);

        // Good frame, back-to-back
        startW = writeCount;
        applyStimulus(8'hA5);
        checkOutput("holdAfterHeader", hold, 1);
        applyStimulus(8'h04);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h13);
        applyStimulus(8'h13);
        checkOutput("goodWrites", writeCount - startW, 4);
        checkOutput("goodA0", addrLog[startW], 0);
        checkOutput("goodA3", addrLog[startW + 3], 3);
        checkOutput("goodD2", dataLog[startW + 2], 8'h00);
        checkOutput("goodD3", dataLog[startW + 3], 8'h13);
        checkOutput("goodConsecutive", writeCycleLog[startW + 3] - writeCycleLog[startW], 3);
        checkOutput("goodFlags", {hold, done, error}, 3'b010);
        idleCycles(3);
        checkOutput("addrHold", mem_addr, 3);
        checkOutput("wdataHold", mem_wdata, 8'h13);

        // Bad checksum
        startW = writeCount;
        applyStimulus(8'hA5);
        checkOutput("headerClearsDone", {hold, done}, 2'b10);
        applyStimulus(8'h02);
        applyStimulus(8'h10);
        applyStimulus(8'h20);
        applyStimulus(8'h31);
        checkOutput("badWrites", writeCount - startW, 2);
        checkOutput("badD1", dataLog[startW + 1], 8'h20);
        checkOutput("badFlags", {hold, done, error}, 3'b001);
        idleCycles(2);

        // Junk before header, header value as payload and checksum
        startW = writeCount;
        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        idleCycles(2);
        checkOutput("junkIgnored", {writeCount - startW, 29'd0, hold, error}, {32'd0, 29'd0, 1'b0, 1'b1});
        applyStimulus(8'hA5);
        checkOutput("errorCleared", error, 0);
        applyStimulus(8'h01);
        applyStimulus(8'hA5);
        applyStimulus(8'hA5);
        checkOutput("hdrPayloadWrites", writeCount - startW, 1);
        checkOutput("hdrPayloadAddr", addrLog[startW], 0);
        checkOutput("hdrPayloadData", dataLog[startW], 8'hA5);
        checkOutput("hdrPayloadFlags", {hold, done, error}, 3'b010);
        idleCycles(2);

        // 256-byte frame with wrap
        startW = writeCount;
        applyStimulus(8'hA5);
        applyStimulus(8'h00);
        for (int i = 0; i < 256; i++) applyStimulus(8'(i));
        applyStimulus(8'h80);
        checkOutput("fullWrites", writeCount - startW, 256);
        checkOutput("fullLastAddr", addrLog[(startW + 255) % 1024], 8'hFF);
        checkOutput("fullLastData", dataLog[(startW + 255) % 1024], 8'hFF);
        badCount = 0;
        for (int i = 0; i < 256; i++) if (shadowMem[i] !== 8'(i)) badCount++;
        checkOutput("fullMemImage", badCount, 0);
        checkOutput("fullFlags", {hold, done, error}, 3'b010);
        idleCycles(2);

        // Timeout abort
        startW = writeCount;
        applyStimulus(8'hA5);
        applyStimulus(8'h03);
        applyStimulus(8'h11);
        idleCycles(TB_TIMEOUT - 2);
        checkOutput("noEarlyTimeout", {hold, error}, 2'b10);
        idleCycles(4);
        checkOutput("timeoutWrites", writeCount - startW, 1);
        checkOutput("timeoutData", dataLog[startW], 8'h11);
        checkOutput("timeoutFlags", {hold, done, error}, 3'b001);
        startW = writeCount;
        applyStimulus(8'h22);
        checkOutput("idleAfterTimeout", {writeCount - startW, 31'd0, hold}, 64'd0);
        applyStimulus(8'hA5);
        checkOutput("timeoutRecover", {hold, error}, 2'b10);
        applyStimulus(8'h01);
        applyStimulus(8'h5A);
        applyStimulus(8'h5A);
        checkOutput("recoverFlags", {hold, done, error}, 3'b010);
        idleCycles(2);

        // Reset mid-frame
        applyStimulus(8'hA5);
        applyStimulus(8'h04);
        applyStimulus(8'h01);
        #2 nReset = 1'b0;
        #1;
        checkOutput("midRstWe", mem_we, 0);
        checkOutput("midRstOut", {rx_ready, hold, done, error, mem_addr, mem_wdata}, 0);
        #3 nReset = 1'b1;
        @(posedge Clock);
        #1;
        startW = writeCount;
        applyStimulus(8'h02);
        applyStimulus(8'h03);
        idleCycles(3);
        checkOutput("postRstIgnored", writeCount - startW, 0);
        checkOutput("postRstHold", hold, 0);
        applyStimulus(8'hA5);
        applyStimulus(8'h01);
        applyStimulus(8'h77);
        applyStimulus(8'h77);
        checkOutput("postRstFrame", {writeCount - startW, 29'd0, hold, done, error}, {32'd1, 29'd0, 3'b010});
        idleCycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
